// File: rtl/image_cache_tile_loader_pkg.sv
// Shared types for the image-cache tile loader.
//   loader_state_e              : FSM states (idle, filling, done pulse)
//   fill_order_e                : raster (x fastest) or column-major (y fastest)
//   struct_ImageCacheTile_Write : one cache write; fields are sized to the largest
//                                 supported widths, the top uses the low bits only
//   tile_cfg_ok()               : tile geometry legality, evaluated at elaboration
package pkg_image_cache_loader;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } loader_state_e;

  typedef enum logic {
    OrderRaster   = 1'b0,
    OrderColMajor = 1'b1
  } fill_order_e;

  localparam int unsigned MaxWordSize = 64;
  localparam int unsigned MaxAddrW    = 32;

  typedef struct packed {
    logic                   we;
    logic [MaxWordSize-1:0] wdata;
    logic [MaxAddrW-1:0]    waddrX;
    logic [MaxAddrW-1:0]    waddrY;
  } struct_ImageCacheTile_Write;

  // The unpacker emits whole beats, so both tile edges must be whole beats.
  function automatic bit tile_cfg_ok(input int unsigned rows, input int unsigned cols,
                                     input int unsigned lanes);
    return (lanes > 0) && (rows > 0) && (cols > 0) &&
           ((rows % lanes) == 0) && ((cols % lanes) == 0);
  endfunction

endpackage

// File: rtl/image_cache_tile_loader_lane_unpacker.sv
// Beat unpacker: holds one accepted multi-pixel beat and presents one lane per cycle,
// lane 0 first.
//   clk, resetn  : clock, synchronous active-low reset
//   flush        : drop the held beat and block acceptance this cycle
//   active       : loader is filling
//   more_beats   : the tile still needs beats
//   data         : packed beat, lane 0 in the low bits
//   data_ready   : source offers a beat
//   data_wanted  : beat may be taken this cycle
//   accept       : beat is taken at the coming edge
//   pix_valid    : pix_data holds a lane to be written this cycle
//   pix_data     : current lane
module lane_unpacker #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned LANES     = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       active,
  input  logic                       more_beats,
  input  logic [LANES*WORD_SIZE-1:0] data,
  input  logic                       data_ready,
  output logic                       data_wanted,
  output logic                       accept,
  output logic                       pix_valid,
  output logic [WORD_SIZE-1:0]       pix_data
);

  localparam int unsigned LW = $clog2(LANES + 1);

  logic [LANES*WORD_SIZE-1:0] beat_q;
  logic [LW-1:0]              lanes_left_q;
  logic [LW-1:0]              lane_idx;

  // Wanted while the last lane is out so a new beat lands with no write bubble.
  assign data_wanted = active && !flush && more_beats && (lanes_left_q <= LW'(1));
  assign accept      = data_wanted && data_ready;
  assign pix_valid   = (lanes_left_q != '0);
  assign lane_idx    = LW'(LANES) - lanes_left_q;

  always_comb begin
    pix_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pix_valid && (lane_idx == LW'(i))) begin
        pix_data = beat_q[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      beat_q       <= '0;
      lanes_left_q <= '0;
    end else if (accept) begin
      beat_q       <= data;
      lanes_left_q <= LW'(LANES);
    end else if (pix_valid) begin
      lanes_left_q <= lanes_left_q - LW'(1);
    end
  end

endmodule

// File: rtl/image_cache_tile_loader.sv
// Image-cache tile loader: takes packed pixel beats and writes one pixel per cycle
// into a ROWS x COLS tile of the image cache at a runtime origin.
//   clk, resetn        : clock, synchronous active-low reset
//   start, abort       : begin a fill (idle only) / return to idle (highest priority)
//   col_major          : fill order, captured with start
//   base_x, base_y     : tile origin, captured with start
//   data, data_ready   : packed beat stream in
//   data_wanted        : beat accepted when high together with data_ready
//   wr_en/wr_data/wr_x/wr_y : cache write port
//   busy, done, loaded : filling / one-cycle completion pulse / tile present
module image_cache_tile_loader
  import pkg_image_cache_loader::*;
#(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ROWS      = 16,
  parameter int unsigned COLS      = 16,
  parameter int unsigned ADDR_X_W  = 8,
  parameter int unsigned ADDR_Y_W  = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       col_major,
  input  logic [ADDR_X_W-1:0]        base_x,
  input  logic [ADDR_Y_W-1:0]        base_y,
  input  logic [LANES*WORD_SIZE-1:0] data,
  input  logic                       data_ready,
  output logic                       data_wanted,
  output logic                       wr_en,
  output logic [WORD_SIZE-1:0]       wr_data,
  output logic [ADDR_X_W-1:0]        wr_x,
  output logic [ADDR_Y_W-1:0]        wr_y,
  output logic                       busy,
  output logic                       done,
  output logic                       loaded
);

  localparam int unsigned TotalBeats = ROWS * COLS / LANES;
  localparam int unsigned XW         = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned YW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW         = $clog2(TotalBeats + 1);

  if (!tile_cfg_ok(ROWS, COLS, LANES)) begin : g_bad_tile
    $error("ROWS and COLS must be non-zero multiples of LANES");
  end
  if (WORD_SIZE > MaxWordSize || ADDR_X_W > MaxAddrW || ADDR_Y_W > MaxAddrW) begin : g_bad_width
    $error("pixel or address width exceeds the write bundle");
  end

  loader_state_e state_q, state_d;
  fill_order_e   order_q;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_X_W-1:0] base_x_q;
  logic [ADDR_Y_W-1:0] base_y_q;
  logic [BW-1:0]       beats_q;
  logic                loaded_q;

  logic                 pix_valid;
  logic [WORD_SIZE-1:0] pix_data;
  logic                 accept;
  logic                 more_beats;
  logic                 write;
  logic                 x_last, y_last, last_pix;
  logic                 start_ok;

  struct_ImageCacheTile_Write wr_bundle;
  logic                       unused_bundle;

  assign busy       = (state_q == StFill);
  assign done       = (state_q == StDone);
  assign loaded     = loaded_q;
  assign more_beats = (beats_q < BW'(TotalBeats));
  assign write      = pix_valid && busy;
  assign x_last     = (x_q == XW'(COLS - 1));
  assign y_last     = (y_q == YW'(ROWS - 1));
  // The final pixel is the far corner in either fill order.
  assign last_pix   = x_last && y_last;
  assign start_ok   = (state_q == StIdle) && start && !abort;

  lane_unpacker #(
    .WORD_SIZE (WORD_SIZE),
    .LANES     (LANES)
  ) u_lane_unpacker (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (abort),
    .active      (busy),
    .more_beats  (more_beats),
    .data        (data),
    .data_ready  (data_ready),
    .data_wanted (data_wanted),
    .accept      (accept),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StFill;
      StFill: if (write && last_pix) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Pixel position after the current write; both counters wrap to 0 at the tile end.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (order_q == OrderRaster) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      if (y_last) begin
        y_d = '0;
        x_d = x_last ? '0 : x_q + XW'(1);
      end else begin
        y_d = y_q + YW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      order_q  <= OrderRaster;
      x_q      <= '0;
      y_q      <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      beats_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (abort) begin
        x_q      <= '0;
        y_q      <= '0;
        beats_q  <= '0;
        loaded_q <= 1'b0;
      end else if (start_ok) begin
        x_q      <= '0;
        y_q      <= '0;
        beats_q  <= '0;
        loaded_q <= 1'b0;
        base_x_q <= base_x;
        base_y_q <= base_y;
        order_q  <= fill_order_e'(col_major);
      end else begin
        if (accept) beats_q <= beats_q + BW'(1);
        if (write) begin
          x_q <= x_d;
          y_q <= y_d;
          if (last_pix) loaded_q <= 1'b1;
        end
      end
    end
  end

  // Write fields stay zero between writes; addresses wrap silently.
  always_comb begin
    wr_bundle    = '0;
    wr_bundle.we = write;
    if (write) begin
      wr_bundle.wdata[WORD_SIZE-1:0]  = pix_data;
      wr_bundle.waddrX[ADDR_X_W-1:0] = base_x_q + ADDR_X_W'(x_q);
      wr_bundle.waddrY[ADDR_Y_W-1:0] = base_y_q + ADDR_Y_W'(y_q);
    end
  end

  assign wr_en   = wr_bundle.we;
  assign wr_data = wr_bundle.wdata[WORD_SIZE-1:0];
  assign wr_x    = wr_bundle.waddrX[ADDR_X_W-1:0];
  assign wr_y    = wr_bundle.waddrY[ADDR_Y_W-1:0];

  assign unused_bundle = ^wr_bundle;

endmodule

// File: tb/tb_image_cache_tile_loader.sv
module tb_image_cache_tile_loader;

  localparam int W      = 8;
  localparam int L      = 2;
  localparam int R      = 4;
  localparam int C      = 4;
  localparam int AX     = 8;
  localparam int AY     = 8;
  localparam int NPIX   = R * C;
  localparam int NBEATS = NPIX / L;

  logic          clk = 1'b0;
  logic          resetn, start, abort, col_major, data_ready;
  logic [AX-1:0] base_x;
  logic [AY-1:0] base_y;
  logic [L*W-1:0] data;
  logic          data_wanted, wr_en, busy, done, loaded;
  logic [W-1:0]  wr_data;
  logic [AX-1:0] wr_x;
  logic [AY-1:0] wr_y;

  always #5 clk = ~clk;

  image_cache_tile_loader #(
    .WORD_SIZE (W),
    .LANES     (L),
    .ROWS      (R),
    .COLS      (C),
    .ADDR_X_W  (AX),
    .ADDR_Y_W  (AY)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .abort       (abort),
    .col_major   (col_major),
    .base_x      (base_x),
    .base_y      (base_y),
    .data        (data),
    .data_ready  (data_ready),
    .data_wanted (data_wanted),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .busy        (busy),
    .done        (done),
    .loaded      (loaded)
  );

  typedef struct {
    bit         cm;
    logic [7:0] bx, by;
    int         mode;   // 0 always ready, 1 toggling, 2 random
    bit         rnd;    // random pixel values
    int         lat;    // accept-to-done cycles, -1 when stalls make it variable
    int         poke;   // write index at which a stray start is pulsed, -1 none
    logic [7:0] fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[6];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc = 0;
  int          nw, beat, first_acc;
  logic [7:0]  pix[NPIX];
  bit          cur_cm;
  logic [7:0]  cur_bx, cur_by;
  logic [15:0] first_xy, last_xy;
  bit          hs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: pixel n goes to origin + (n mod width, n div width) or its transpose.
  function automatic logic [23:0] model_write(input int n);
    int xo, yo;
    if (cur_cm) begin
      xo = n / R;
      yo = n % R;
    end else begin
      xo = n % C;
      yo = n / C;
    end
    return {pix[n], 8'(int'(cur_bx) + xo), 8'(int'(cur_by) + yo)};
  endfunction

  function automatic logic [15:0] beat_word(input int b);
    if (b < NBEATS) return {pix[2*b+1], pix[2*b]};
    return 16'($urandom);
  endfunction

  function automatic bit ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Drive this cycle's source inputs, then sample and score any write.
  task automatic sample(input bit rdy);
    data_ready = rdy;
    data       = beat_word(beat);
    #1;
    if (wr_en) begin
      if (nw < NPIX) begin
        check($sformatf("write%0d", nw), 64'({wr_data, wr_x, wr_y}), 64'(model_write(nw)));
        if (nw == 0) first_xy = {wr_x, wr_y};
        if (nw == NPIX - 1) last_xy = {wr_x, wr_y};
      end
      nw++;
    end
    hs = data_wanted && data_ready;
    if (hs && first_acc < 0) first_acc = cyc;
  endtask

  task automatic finish_cycle();
    bit took;
    took = hs;
    tick();
    if (took) beat++;
  endtask

  task automatic setup_pixels(input bit rnd);
    for (int p = 0; p < NPIX; p++) pix[p] = rnd ? 8'($urandom) : 8'(p);
  endtask

  task automatic begin_fill(input bit cm, input logic [7:0] bx, input logic [7:0] by);
    cur_cm = cm; cur_bx = bx; cur_by = by;
    col_major = cm; base_x = bx; base_y = by;
    start = 1'b1; data_ready = 1'b0;
    tick();
    start = 1'b0;
    // Captured at start; scrambling them afterwards must not matter.
    base_x = 8'($urandom); base_y = 8'($urandom); col_major = ~cm;
    nw = 0; beat = 0; first_acc = -1;
  endtask

  task automatic run_fill(input vec_t v, input int row);
    int  done_cyc;
    bit  poked;
    setup_pixels(v.rnd);
    begin_fill(v.cm, v.bx, v.by);
    done_cyc = -1;
    poked    = 1'b0;
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      if (v.poke >= 0 && !poked && nw == v.poke) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      sample(ready_for(v.mode, c));
      if (c == 0) begin
        check($sformatf("r%0d_busy_after_start", row), 64'(busy), 64'(1));
        check($sformatf("r%0d_loaded_cleared", row), 64'(loaded), 64'(0));
        check($sformatf("r%0d_wanted_after_start", row), 64'(data_wanted), 64'(1));
      end
      if (done) begin
        done_cyc = cyc;
        check($sformatf("r%0d_done_loaded", row), 64'(loaded), 64'(1));
        check($sformatf("r%0d_done_busy", row), 64'(busy), 64'(0));
      end
      finish_cycle();
    end
    start = 1'b0;
    check($sformatf("r%0d_done_seen", row), 64'(done_cyc >= 0), 64'(1));
    check($sformatf("r%0d_write_count", row), 64'(nw), 64'(NPIX));
    check($sformatf("r%0d_beat_count", row), 64'(beat), 64'(NBEATS));
    check($sformatf("r%0d_first_xy", row), 64'(first_xy), 64'({v.fx, v.fy}));
    check($sformatf("r%0d_last_xy", row), 64'(last_xy), 64'({v.lx, v.ly}));
    if (v.lat >= 0 && done_cyc >= 0)
      check($sformatf("r%0d_done_latency", row), 64'(done_cyc - first_acc), 64'(v.lat));
    #1;
    check($sformatf("r%0d_after_done", row), 64'({done, loaded, busy, wr_en}), 64'(4'b0100));
  endtask

  // Raster fill from (0,0), stopped right after the given number of writes.
  task automatic partial_fill(input int target);
    setup_pixels(1'b0);
    begin_fill(1'b0, 8'd0, 8'd0);
    for (int c = 0; c < 100 && nw < target; c++) begin
      sample(1'b1);
      finish_cycle();
    end
    check($sformatf("partial_%0d_reached", target), 64'(nw), 64'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wanted"}, 64'(data_wanted), 64'(0));
    check({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    check({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    check({tag, "_wr_x"}, 64'(wr_x), 64'(0));
    check({tag, "_wr_y"}, 64'(wr_y), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_loaded"}, 64'(loaded), 64'(0));
  endtask

  initial begin
    bit any_done;

    vecs[0] = '{cm:1'b0, bx:8'd0,   by:8'd0,   mode:0, rnd:1'b0, lat:17, poke:-1,
                fx:8'd0,   fy:8'd0,   lx:8'd3,  ly:8'd3};
    vecs[1] = '{cm:1'b1, bx:8'd0,   by:8'd0,   mode:0, rnd:1'b0, lat:17, poke:-1,
                fx:8'd0,   fy:8'd0,   lx:8'd3,  ly:8'd3};
    vecs[2] = '{cm:1'b0, bx:8'd254, by:8'd1,   mode:0, rnd:1'b0, lat:17, poke:-1,
                fx:8'd254, fy:8'd1,   lx:8'd1,  ly:8'd4};
    vecs[3] = '{cm:1'b0, bx:8'd0,   by:8'd0,   mode:1, rnd:1'b0, lat:-1, poke:7,
                fx:8'd0,   fy:8'd0,   lx:8'd3,  ly:8'd3};
    vecs[4] = '{cm:1'b1, bx:8'd253, by:8'd254, mode:2, rnd:1'b1, lat:-1, poke:-1,
                fx:8'd253, fy:8'd254, lx:8'd0,  ly:8'd1};
    vecs[5] = '{cm:1'b0, bx:8'd17,  by:8'd99,  mode:2, rnd:1'b1, lat:-1, poke:3,
                fx:8'd17,  fy:8'd99,  lx:8'd20, ly:8'd102};

    resetn = 1'b0; start = 1'b0; abort = 1'b0; col_major = 1'b0;
    base_x = '0; base_y = '0; data = '0; data_ready = 1'b0;
    beat = 0; nw = 0; first_acc = -1;
    repeat (3) tick();
    data_ready = 1'b1;
    data       = 16'hA5A5;
    #1;
    check_reset_outputs("reset");
    data_ready = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_fill(vecs[i], i);

    // Abort mid-fill: nothing accepted in the abort cycle, idle and not loaded after.
    partial_fill(5);
    abort = 1'b1;
    data_ready = 1'b1;
    data = beat_word(beat);
    #1;
    check("abort_wanted_forced_low", 64'(data_wanted), 64'(0));
    tick();
    abort = 1'b0;
    #1;
    check("abort_idle", 64'({busy, data_wanted, wr_en, loaded, done}), 64'(0));
    any_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      any_done |= done;
    end
    data_ready = 1'b0;
    check("abort_no_done", 64'(any_done), 64'(0));
    run_fill(vecs[0], 10);

    // start and abort together while idle and loaded: abort wins and clears loaded.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("start_abort_idle", 64'({busy, data_wanted}), 64'(0));
    check("start_abort_loaded", 64'(loaded), 64'(0));
    tick();
    #1;
    check("start_abort_still_idle", 64'(busy), 64'(0));

    // Reset in the middle of a fill.
    partial_fill(6);
    resetn = 1'b0;
    tick();
    #1;
    check_reset_outputs("rst_mid");
    resetn = 1'b1;
    tick();
    #1;
    check("rst_mid_after_release", 64'({busy, wr_en}), 64'(0));
    run_fill(vecs[1], 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
